// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
//   Shared definitions for the systolic_feeder block:
//     feeder_state_t : feeder FSM state encoding (also exported on dbg_state)
//     PHASE_CNT_W    : width of the per-phase counters (weight rows, drain)
//     STALL_CNT_W    : width of the optional stall counter
//     drain_cycles() : number of zero-flush cycles for an n-lane array
// ---------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } feeder_state_t;

    // Wide enough for weight-row and drain counting up to 128 lanes.
    localparam int PHASE_CNT_W = 8;
    localparam int STALL_CNT_W = 16;

    // The last activation enters lane MATRIX_SIZE-1 late and then needs to
    // ripple across the array, so 2n-1 zero cycles flush every partial sum.
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/skew_delay.sv
// ---------------------------------------------------------------------------
// skew_delay
//   DELAY-stage register line for one activation lane (data + valid bit).
//   DELAY = 0 degenerates to a plain wire.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset (clears line)
//     d_in, v_in      : lane data / valid entering the line
//     d_out, v_out    : lane data / valid after DELAY cycles
// ---------------------------------------------------------------------------
module skew_delay #(
    parameter int DELAY = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    generate
        if (DELAY == 0) begin : g_wire
            // Clock and reset are not needed for a zero-length line.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign d_out = d_in;
            assign v_out = v_in;
        end else begin : g_line
            logic [DELAY-1:0][WIDTH-1:0] data_q;
            logic [DELAY-1:0]            valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= '0;
                end else begin
                    data_q[0]  <= d_in;
                    valid_q[0] <= v_in;
                    for (int i = 1; i < DELAY; i++) begin
                        data_q[i]  <= data_q[i-1];
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            assign d_out = data_q[DELAY-1];
            assign v_out = valid_q[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
//   Upstream stage of the matrix_multiply systolic array. Preloads
//   MATRIX_SIZE weight rows (ld_weight strobe), then streams activation
//   vectors onto in_data with lane r delayed r cycles, flushes
//   2*MATRIX_SIZE-1 zero cycles and pulses done.
//
//   Optional feature macro: FEEDER_STALL_CNT_EN adds the stall_count output
//   (STREAM cycles where the feeder was ready but no vector was offered).
//
//   Ports:
//     clk, reset               : clock, asynchronous active-high reset
//     cfg_start, cfg_num_vecs  : job start and vector count (sampled in IDLE)
//     w_valid/w_ready, w_data  : weight-row stream (lane j -> in_weights[j])
//     a_valid/a_ready, a_data  : activation stream (lane r -> array row r)
//     in_data, lane_valid      : skewed activations and per-lane valid
//     in_weights, ld_weight    : weight row and its one-cycle load strobe
//     busy, done               : not-IDLE flag, end-of-job pulse
//     stall_count              : (FEEDER_STALL_CNT_EN only) stall counter
//     dbg_state                : current FSM state
//
//   Handshake: a transfer happens in a cycle where valid and ready are both
//   1. Ready depends only on state and counters, never on valid; valid may be
//   raised or dropped freely, data is only consumed on a transfer.
// ---------------------------------------------------------------------------
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter  int MATRIX_SIZE = 2,
    parameter  int DATA_SIZE   = 32,
    parameter  int MAX_VECS    = 16,
    localparam int VEC_W       = $clog2(MAX_VECS + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cfg_start,
    input  logic [VEC_W-1:0]                      cfg_num_vecs,
    input  logic                                  w_valid,
    output logic                                  w_ready,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] w_data,
    input  logic                                  a_valid,
    output logic                                  a_ready,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] a_data,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] in_data,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] in_weights,
    output logic                                  ld_weight,
    output logic [MATRIX_SIZE-1:0]                lane_valid,
    output logic                                  busy,
    output logic                                  done,
`ifdef FEEDER_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0]                stall_count,
`endif
    output feeder_state_t                         dbg_state
);

    localparam logic [PHASE_CNT_W-1:0] ROW_LAST   = PHASE_CNT_W'(MATRIX_SIZE - 1);
    localparam logic [PHASE_CNT_W-1:0] DRAIN_LAST =
        PHASE_CNT_W'(drain_cycles(MATRIX_SIZE) - 1);
    localparam logic [VEC_W-1:0]       VEC_MAX    = VEC_W'(MAX_VECS);

    feeder_state_t state, next_state;

    logic [VEC_W-1:0]       vec_target;   // latched (saturated) job length
    logic [VEC_W-1:0]       vec_cnt;      // vectors accepted so far
    logic [VEC_W-1:0]       vec_cnt_nxt;
    logic [VEC_W-1:0]       num_vecs_sat;
    logic [PHASE_CNT_W-1:0] row_cnt;      // weight rows accepted so far
    logic [PHASE_CNT_W-1:0] drain_cnt;    // zero-flush cycles elapsed

    logic start_fire;
    logic w_fire;
    logic a_fire;

    // Input register feeding the per-lane delay lines.
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] in_reg_data;
    logic                                  in_reg_valid;

    assign start_fire   = cfg_start && (state == IDLE);
    assign w_fire       = w_valid && w_ready;
    assign a_fire       = a_valid && a_ready;
    assign vec_cnt_nxt  = vec_cnt + 1'b1;
    assign num_vecs_sat = (cfg_num_vecs > VEC_MAX) ? VEC_MAX : cfg_num_vecs;
    assign dbg_state    = state;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        w_ready    = 1'b0;
        a_ready    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (cfg_start) begin
                    next_state = LOAD_W;
                end
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && (row_cnt == ROW_LAST)) begin
                    next_state = (vec_target == '0) ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                a_ready = (vec_cnt < vec_target);
                if (a_valid && a_ready && (vec_cnt_nxt == vec_target)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Job counters. Each one is bounded by the state that advances it, so
    // none of them can wrap.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_target <= '0;
            vec_cnt    <= '0;
            row_cnt    <= '0;
            drain_cnt  <= '0;
        end else begin
            if (start_fire) begin
                vec_target <= num_vecs_sat;
                vec_cnt    <= '0;
                row_cnt    <= '0;
                drain_cnt  <= '0;
            end
            if (w_fire) begin
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end
            if (a_fire) begin
                vec_cnt <= vec_cnt_nxt;
            end
            if (state == DRAIN) begin
                drain_cnt <= (drain_cnt == DRAIN_LAST) ? '0 : drain_cnt + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Weight path: each accepted row is shown for exactly one strobe cycle;
    // the row value itself holds until the next load.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_weights <= '0;
            ld_weight  <= 1'b0;
        end else begin
            ld_weight <= w_fire;
            if (w_fire) begin
                in_weights <= w_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Activation input register. Any cycle without an accepted vector loads
    // a zero bubble with valid=0, which keeps the lane skew aligned through
    // stalls and provides the zero flush during DRAIN.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_reg_data  <= '0;
            in_reg_valid <= 1'b0;
        end else begin
            in_reg_valid <= a_fire;
            in_reg_data  <= a_fire ? a_data : '0;
        end
    end

    // Lane r gets r extra stages so row r of the array sees its element r
    // cycles after row 0 (diagonal wavefront).
    for (genvar r = 0; r < MATRIX_SIZE; r++) begin : g_lane
        skew_delay #(
            .DELAY (r),
            .WIDTH (DATA_SIZE)
        ) u_skew (
            .clk   (clk),
            .rst   (reset),
            .d_in  (in_reg_data[r]),
            .v_in  (in_reg_valid),
            .d_out (in_data[r]),
            .v_out (lane_valid[r])
        );
    end

`ifdef FEEDER_STALL_CNT_EN
    // -----------------------------------------------------------------------
    // Stall counter: cycles the feeder could have taken a vector but none
    // was offered. Saturates, clears at job start, holds afterwards.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (start_fire) begin
            stall_count <= '0;
        end else if ((state == STREAM) && a_ready && !a_valid &&
                     (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule
